// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, status bit positions
// and the sequencer state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SHL = 3'd2,
        OP_SHR = 3'd3,
        OP_MUL = 3'd4,
        OP_DIV = 3'd5,
        OP_LDI = 3'd6,
        OP_NOP = 3'd7
    } opcode_e;

    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

    localparam logic [3:0] STATUS_DIV0 = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB_LO,
        S_WB_HI
    } seq_state_e;

    // Ops whose result is produced by the ALU and therefore update status.
    function automatic logic is_alu_op(input opcode_e op);
        return (op != OP_LDI) && (op != OP_NOP);
    endfunction

    function automatic logic is_wide_op(input opcode_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational operand read ports, one debug read port
// and a single synchronous write port; all entries clear on reset.
module alu_regfile #(
    parameter int WIDTH = 8,
    parameter int REGS  = 8,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr1,
    input  logic [AW-1:0]    i_raddr2,
    input  logic [AW-1:0]    i_dbg_addr,
    output logic [WIDTH-1:0] o_rdata1,
    output logic [WIDTH-1:0] o_rdata2,
    output logic [WIDTH-1:0] o_dbg_data
);

    logic [WIDTH-1:0] r_mem [REGS];

    // NOTE: resetting the array makes every entry a flop with reset; this is
    // intentional because software relies on all registers reading 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1   = r_mem[i_raddr1];
    assign o_rdata2   = r_mem[i_raddr2];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer in front of a purely combinational ALU: fetches
// operands, captures ALU results and owns register and status write-back.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int REGS  = 8,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [3:0]       alu_status_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_upper,
    input  logic [3:0]       alu_status_out,
    output logic             done,
    output logic [3:0]       status,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    seq_state_e       r_state;
    opcode_e          r_op;
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_rs1;
    logic [AW-1:0]    r_rs2;
    logic [WIDTH-1:0] r_imm;
    opcode_e          r_alu_opcode;
    logic [WIDTH-1:0] r_alu_op1;
    logic [WIDTH-1:0] r_alu_op2;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_upper;
    logic [3:0]       r_flags;
    logic             r_div0;
    logic [3:0]       r_status;
    logic             r_done;

    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rdata1;
    logic [WIDTH-1:0] w_rdata2;
    logic             w_exec_div0;
    logic             w_exec_to_hi;
    opcode_e          w_instr_op;

    assign w_instr_op   = opcode_e'(instr_op);
    assign w_exec_div0  = (r_op == OP_DIV) && (r_alu_op2 == '0);
    assign w_exec_to_hi = is_wide_op(r_op) && !w_exec_div0;

    alu_regfile #(.WIDTH(WIDTH), .REGS(REGS)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_raddr1   (r_rs1),
        .i_raddr2   (r_rs2),
        .i_dbg_addr (dbg_addr),
        .o_rdata1   (w_rdata1),
        .o_rdata2   (w_rdata2),
        .o_dbg_data (dbg_data)
    );

    // NOTE: every state and output register uses non-blocking assignment so
    // all of them update together on the edge and reads see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= OP_NOP;
            r_rd         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_imm        <= '0;
            r_alu_opcode <= OP_ADD;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_result     <= '0;
            r_upper      <= '0;
            r_flags      <= '0;
            r_div0       <= 1'b0;
            r_status     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_op  <= w_instr_op;
                        r_rd  <= instr_rd;
                        r_rs1 <= instr_rs1;
                        r_rs2 <= instr_rs2;
                        r_imm <= instr_imm;
                        if (is_alu_op(w_instr_op)) begin
                            r_state <= S_READ;
                        end else begin
                            r_state <= S_WB_LO;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_alu_opcode <= r_op;
                    r_alu_op1    <= w_rdata1;
                    r_alu_op2    <= w_rdata2;
                    r_state      <= S_EXEC;
                end
                S_EXEC: begin
                    r_result <= alu_result;
                    r_upper  <= alu_upper;
                    r_flags  <= alu_status_out;
                    r_div0   <= w_exec_div0;
                    r_done   <= !w_exec_to_hi;
                    r_state  <= S_WB_LO;
                end
                S_WB_LO: begin
                    if (is_alu_op(r_op)) begin
                        r_status <= r_div0 ? STATUS_DIV0 : r_flags;
                    end
                    // A zero divisor retires here; otherwise MUL/DIV still owe the high half.
                    if (is_wide_op(r_op) && !r_div0) begin
                        r_state <= S_WB_HI;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WB_HI: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: defaults are assigned before the case so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_rd;
        w_wdata = r_result;
        case (r_state)
            S_WB_LO: begin
                case (r_op)
                    OP_DIV:  w_we = !r_div0;
                    OP_LDI: begin
                        w_we    = 1'b1;
                        w_wdata = r_imm;
                    end
                    OP_NOP:  w_we = 1'b0;
                    default: w_we = 1'b1;
                endcase
            end
            S_WB_HI: begin
                w_we    = 1'b1;
                w_waddr = r_rd + AW'(1);
                w_wdata = r_upper;
            end
            default: w_we = 1'b0;
        endcase
    end

    assign instr_ready   = (r_state == S_IDLE);
    assign alu_opcode    = r_alu_opcode;
    assign alu_op1       = r_alu_op1;
    assign alu_op2       = r_alu_op2;
    assign alu_status_in = r_status;
    assign status        = r_status;
    assign done          = r_done;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small combinational ALU model
// driving the ALU-facing inputs.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int REGS  = 8;
    localparam int AW    = 3;

    logic             clk;
    logic             rst_n;
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       instr_op;
    logic [AW-1:0]    instr_rd;
    logic [AW-1:0]    instr_rs1;
    logic [AW-1:0]    instr_rs2;
    logic [WIDTH-1:0] instr_imm;
    logic [2:0]       alu_opcode;
    logic [WIDTH-1:0] alu_op1;
    logic [WIDTH-1:0] alu_op2;
    logic [3:0]       alu_status_in;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_upper;
    logic [3:0]       alu_status_out;
    logic             done;
    logic [3:0]       status;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    int vectors     = 0;
    int miscompares = 0;

    alu_sequencer #(.WIDTH(WIDTH), .REGS(REGS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_op       (instr_op),
        .instr_rd       (instr_rd),
        .instr_rs1      (instr_rs1),
        .instr_rs2      (instr_rs2),
        .instr_imm      (instr_imm),
        .alu_opcode     (alu_opcode),
        .alu_op1        (alu_op1),
        .alu_op2        (alu_op2),
        .alu_status_in  (alu_status_in),
        .alu_result     (alu_result),
        .alu_upper      (alu_upper),
        .alu_status_out (alu_status_out),
        .done           (done),
        .status         (status),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: flags {V,C,N,Z}; C is carry for ADD, borrow for SUB.
    logic [WIDTH:0]     a_sum;
    logic [2*WIDTH-1:0] a_prod;
    always_comb begin
        a_sum          = '0;
        a_prod         = '0;
        alu_result     = '0;
        alu_upper      = '0;
        alu_status_out = '0;
        case (opcode_e'(alu_opcode))
            OP_ADD: begin
                a_sum = {1'b0, alu_op1} + {1'b0, alu_op2} + {{WIDTH{1'b0}}, alu_status_in[ST_C]};
                alu_result = a_sum[WIDTH-1:0];
                alu_status_out[ST_C] = a_sum[WIDTH];
                alu_status_out[ST_V] = (alu_op1[WIDTH-1] == alu_op2[WIDTH-1]) &&
                                       (a_sum[WIDTH-1] != alu_op1[WIDTH-1]);
            end
            OP_SUB: begin
                a_sum = {1'b0, alu_op1} - {1'b0, alu_op2};
                alu_result = a_sum[WIDTH-1:0];
                alu_status_out[ST_C] = a_sum[WIDTH];
                alu_status_out[ST_V] = (alu_op1[WIDTH-1] != alu_op2[WIDTH-1]) &&
                                       (a_sum[WIDTH-1] != alu_op1[WIDTH-1]);
            end
            OP_SHL: alu_result = alu_op1 << alu_op2[2:0];
            OP_SHR: alu_result = alu_op1 >> alu_op2[2:0];
            OP_MUL: begin
                a_prod     = alu_op1 * alu_op2;
                alu_result = a_prod[WIDTH-1:0];
                alu_upper  = a_prod[2*WIDTH-1:WIDTH];
                alu_status_out[ST_C] = (alu_upper != '0);
                alu_status_out[ST_V] = (alu_upper != '0);
            end
            OP_DIV: begin
                if (alu_op2 != '0) begin
                    alu_result = alu_op1 / alu_op2;
                    alu_upper  = alu_op1 % alu_op2;
                end
            end
            default: alu_result = '0;
        endcase
        if (opcode_e'(alu_opcode) != OP_MUL) begin
            alu_status_out[ST_N] = alu_result[WIDTH-1];
        end
        alu_status_out[ST_Z] = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input int idx, input logic [WIDTH-1:0] exp, input string tag);
        dbg_addr = AW'(idx);
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        @(posedge clk); #1;
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) check({tag, "_ready_timeout"}, 32'(instr_ready), 32'd1);
    endtask

    // Issues one instruction and checks done latency, ready low until done,
    // ready back the cycle after, and that done is a single-cycle pulse.
    task automatic issue(input opcode_e op, input int rd, input int rs1, input int rs2,
                         input logic [WIDTH-1:0] imm, input int exp_lat, input string tag);
        int   lat = 0;
        logic ready_ok = 1'b1;
        logic ready_after = 1'b0;
        logic done_after = 1'b1;
        wait_ready(tag);
        instr_op    = op;
        instr_rd    = AW'(rd);
        instr_rs1   = AW'(rs1);
        instr_rs2   = AW'(rs2);
        instr_imm   = imm;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (lat == 0) begin
                if (instr_ready !== 1'b0) ready_ok = 1'b0;
                if (done === 1'b1) lat = k;
            end else if (k == lat + 1) begin
                ready_after = instr_ready;
                done_after  = done;
            end
            @(posedge clk); #1;
        end
        check({tag, "_latency"},     32'(lat),         32'(exp_lat));
        check({tag, "_ready_low"},   32'(ready_ok),    32'd1);
        check({tag, "_ready_after"}, 32'(ready_after), 32'd1);
        check({tag, "_done_pulse"},  32'(done_after),  32'd0);
    endtask

    logic [8:0] done_mask;
    logic [8:0] ready_mask;
    logic       done_seen;

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_rd    = '0;
        instr_rs1   = '0;
        instr_rs2   = '0;
        instr_imm   = '0;
        dbg_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ready",  32'(instr_ready), 32'd1);
        check("rst_done",   32'(done),        32'd0);
        check("rst_status", 32'(status),      32'd0);
        check("rst_op1",    32'(alu_op1),     32'd0);
        chk_reg(0, 8'h00, "rst_r0");
        chk_reg(7, 8'h00, "rst_r7");

        // LDI + ADD with carry out and zero result
        issue(OP_LDI, 1, 0, 0, 8'hFF, 1, "ldi_r1");
        issue(OP_LDI, 2, 0, 0, 8'h01, 1, "ldi_r2");
        issue(OP_ADD, 3, 1, 2, 8'h00, 3, "add_r3");
        chk_reg(3, 8'h00, "add_r3_val");
        chk_reg(1, 8'hFF, "add_r1_kept");
        check("add_status",    32'(status),        32'h5);
        check("add_status_in", 32'(alu_status_in), 32'h5);

        // MUL 200*3 = 0x0258
        issue(OP_LDI, 4, 0, 0, 8'd200, 1, "ldi_r4");
        issue(OP_LDI, 5, 0, 0, 8'd3,   1, "ldi_r5");
        issue(OP_MUL, 6, 4, 5, 8'h00,  4, "mul_r6");
        chk_reg(6, 8'h58, "mul_lo");
        chk_reg(7, 8'h02, "mul_hi");
        check("mul_status", 32'(status), 32'hC);

        // DIV 100/7 with high half wrapping from R7 to R0
        issue(OP_LDI, 0, 0, 0, 8'd100, 1, "ldi_r0");
        issue(OP_LDI, 1, 0, 0, 8'd7,   1, "ldi_r1b");
        issue(OP_DIV, 7, 0, 1, 8'h00,  4, "div_r7");
        chk_reg(7, 8'd14, "div_quot");
        chk_reg(0, 8'd2,  "div_rem_wrap");
        check("div_status", 32'(status), 32'h0);

        // DIV by zero: no writes, status V only, early done
        issue(OP_LDI, 2, 0, 0, 8'h00, 1, "ldi_r2z");
        issue(OP_DIV, 5, 0, 2, 8'h00, 3, "div0");
        chk_reg(5, 8'd3,  "div0_r5_kept");
        chk_reg(6, 8'h58, "div0_r6_kept");
        chk_reg(0, 8'd2,  "div0_r0_kept");
        check("div0_status", 32'(status), 32'h8);

        // NOP retires without touching anything
        issue(OP_NOP, 5, 0, 0, 8'hAA, 1, "nop");
        chk_reg(5, 8'd3, "nop_r5_kept");
        check("nop_status", 32'(status), 32'h8);

        // Back-to-back SUBs with valid held; second must see updated R3
        wait_ready("b2b");
        instr_op    = OP_SUB;
        instr_rd    = 3'd3;
        instr_rs1   = 3'd1;
        instr_rs2   = 3'd2;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_rd    = 3'd4;
        instr_rs1   = 3'd3;
        instr_rs2   = 3'd1;
        done_mask   = '0;
        ready_mask  = '0;
        for (int k = 1; k <= 8; k++) begin
            done_mask[k]  = done;
            ready_mask[k] = instr_ready;
            if (k == 5) instr_valid = 1'b0;
            @(posedge clk); #1;
        end
        check("b2b_done_cycles",  32'(done_mask),  32'h088);
        check("b2b_ready_cycles", 32'(ready_mask), 32'h110);
        chk_reg(3, 8'h07, "b2b_r3");
        chk_reg(4, 8'h00, "b2b_r4");
        check("b2b_status", 32'(status), 32'h1);

        // Reset during EXEC of an ADD discards it
        wait_ready("rst_exec");
        instr_op    = OP_ADD;
        instr_rd    = 3'd3;
        instr_rs1   = 3'd1;
        instr_rs2   = 3'd3;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        done_seen   = done;
        @(posedge clk); #1;
        done_seen   = done_seen | done;
        rst_n       = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            done_seen = done_seen | done;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            done_seen = done_seen | done;
        end
        check("rst_exec_no_done", 32'(done_seen),   32'd0);
        check("rst_exec_ready",   32'(instr_ready), 32'd1);
        check("rst_exec_status",  32'(status),      32'd0);
        check("rst_exec_op1",     32'(alu_op1),     32'd0);
        chk_reg(1, 8'h00, "rst_exec_r1");
        chk_reg(3, 8'h00, "rst_exec_r3");
        chk_reg(6, 8'h00, "rst_exec_r6");
        chk_reg(7, 8'h00, "rst_exec_r7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequencer directly upstream of the ALU. It accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal register file. It drives the combinational ALU, then writes the result and status flags back. Multi-cycle behaviour, operand storage and status ownership live here, so the ALU stays purely combinational.

## Interface
Parameters:
- WIDTH, 8, datapath width of registers and ALU operands
- REGS, 8, register-file depth (power of two); AW = log2(REGS)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept (IDLE only)
- instr_op  in  3  opcode: ADD=0, SUB=1, SHL=2, SHR=3, MUL=4, DIV=5, LDI=6, NOP=7
- instr_rd, instr_rs1, instr_rs2  in  AW each  destination and source register indices
- instr_imm  in  WIDTH  immediate for LDI
- alu_opcode  out  3  opcode to ALU (registered)
- alu_op1, alu_op2  out  WIDTH  operands to ALU (registered)
- alu_status_in  out  4  current status register to ALU
- alu_result  in  WIDTH  ALU low result (sum, difference, shifted, product low, quotient)
- alu_upper  in  WIDTH  product high / remainder; ignored for other ops
- alu_status_out  in  4  flags from ALU, {V,C,N,Z}
- done  out  1  one-cycle pulse when the instruction retires
- status  out  4  status register {V,C,N,Z}
- dbg_addr  in  AW  debug read index
- dbg_data  out  WIDTH  combinational read of register dbg_addr

## Operation
- States: IDLE, READ, EXEC, WB_LO, WB_HI.
- IDLE: instr_ready=1.
  - On valid&ready, latch op, rd, rs1, rs2 and imm.
  - LDI/NOP → WB_LO. Others → READ.
- READ: load alu_op1=R[rs1], alu_op2=R[rs2], alu_opcode=op → EXEC.
- EXEC: ALU settles. At the clock edge, capture alu_result, alu_upper and alu_status_out → WB_LO.
- WB_LO:
  - ADD/SUB/SHL/SHR: write R[rd]=result and status=captured flags; assert done → IDLE.
  - MUL/DIV: write R[rd]=result and status → WB_HI.
  - LDI: write R[rd]=imm; status unchanged; done → IDLE.
  - NOP: no write; done → IDLE.
- WB_HI: write R[(rd+1) mod REGS]=upper; assert done → IDLE.
- DIV with op2==0:
  - In WB_LO, write no register and set status to {V=1,C=0,N=0,Z=0}.
  - Assert done in WB_LO → IDLE; skip WB_HI.
- Register hazards: operands are sampled in READ, before any write, so rd==rs1/rs2 is safe. For MUL/DIV with rd=REGS-1, the high half wraps to R[0].
- Arithmetic results and flags are entirely the ALU's. The sequencer performs no arithmetic beyond the rd+1 wrap and the zero-divisor check.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, all R[i]=0, status=0, alu_opcode/op1/op2=0, done=0, instr_ready=1 after reset.
  - Reset mid-instruction discards it: no write, no done.
- Let the handshake edge be cycle t. done is high during:
  - ADD/SUB/SHL/SHR, and DIV-by-zero: t+3.
  - MUL/DIV: t+4.
  - LDI/NOP: t+1.
- Register and status writes take effect at the end of the done cycle. dbg_data reflects them from the next cycle.
- instr_ready is 0 from t+1 through the done cycle inclusive. It is 1 the cycle after done, so back-to-back accept is possible.
- instr_valid while not ready is ignored; the upstream must hold it.
- alu_status_in = status at all times (carry-in for ADD).

## Structure
- Package alu_pkg:
  - opcode enum (shared with ALU)
  - status bit indices V=3, C=2, N=1, Z=0
  - sequencer state enum
- Sub-module alu_regfile:
  - REGS×WIDTH storage with two combinational read ports plus the debug port.
  - One synchronous write port, cleared on reset.
- FSM, operand and result registers, and status live in alu_sequencer.

## Test plan
- Reset, then LDI R1=0xFF; LDI R2=0x01; ADD R3=R1+R2 → R3=0x00, status Z=1 C=1, done at t+3, ready low t+1..t+3.
- LDI R4=200, R5=3; MUL rd=6 → R6=0x58, R7=0x02, done at t+4.
- LDI R0=100, R1=7; DIV rd=7 → R7=14, R0=2 (wrap), done at t+4.
- DIV by R2=0 → no register changes, status=V only, done at t+3.
- Back-to-back: hold valid with two SUBs (R3=R1-R2 then R4=R3-R1). The second is accepted the cycle after the first done and uses the updated R3.
- Assert rst_n=0 during EXEC of an ADD → no done, all registers and status read 0, instr_ready=1 after reset release.
